// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin grant arbiter family.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Bit width needed to hold values 0..v-1; never less than 1.
  function automatic int idx_w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: rotate by ptr, find the lowest set bit, rotate back.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          win,
  output logic [idx_w(N)-1:0]   idx
);

  localparam int PW = idx_w(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  pos;
  logic           found;

  always_comb begin
    dbl   = {req, req};
    rot   = N'(dbl >> ptr);
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = PW'(i);
      end
    end
    // N is a power of two, so the PW-bit add wraps mod N for free.
    idx = pos + ptr;
    win = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, forced idle bubble and per-grant hold timer.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout
);

  localparam int PW = idx_w(N);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [N-1:0]  win;
  logic [PW-1:0] win_idx;

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .idx (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (|req) begin
            state       <= GRANT;
            grant       <= win;
            grant_valid <= 1'b1;
            ptr         <= win_idx + PW'(1);
            cnt         <= '0;
          end
        end
        GRANT: begin
          if (done || !(|(req & grant))) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
          timeout     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scoreboard bench for rr_grant_arbiter (N=4, MAX_HOLD=15).
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic       t;
  } exp_t;

  exp_t sb[$];

  rr_grant_arbiter #(.N(4), .MAX_HOLD(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int enc(input logic [3:0] g);
    int r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic [3:0] r, input logic d,
                      input logic [3:0] eg, input logic et);
    exp_t e;
    req  = r;
    done = d;
    sb.push_back('{tag, eg, et});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "_grant"}, 8'(grant), 8'(e.g));
    chk({e.tag, "_timeout"}, 8'(timeout), 8'(e.t));
    chk({e.tag, "_valid"}, 8'(grant_valid), 8'(e.g != 4'b0000));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot0", 8'($onehot0(grant)), 8'd1);
      chk("valid_vs_grant", 8'(grant_valid), 8'(grant != 4'b0000));
    end
  end

  initial begin
    // Reset held with all masters requesting.
    req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 8'(grant), 8'h00);
    chk("rst_valid", 8'(grant_valid), 8'h00);
    chk("rst_timeout", 8'(timeout), 8'h00);
    rst_n = 1'b1;
    step("first", 4'b1111, 1'b0, 4'b0001, 1'b0);
    chk("first_ptr", 8'(dut.ptr), 8'd1);
    chk("enc0", 8'(enc(grant)), 8'd0);

    // Rotation with done pulsed one cycle after each grant.
    step("rot_rel0", 4'b1111, 1'b1, 4'b0000, 1'b0);
    step("rot_g1",   4'b1111, 1'b0, 4'b0010, 1'b0);
    chk("enc1", 8'(enc(grant)), 8'd1);
    step("rot_rel1", 4'b1111, 1'b1, 4'b0000, 1'b0);
    step("rot_g2",   4'b1111, 1'b0, 4'b0100, 1'b0);
    chk("enc2", 8'(enc(grant)), 8'd2);
    step("rot_rel2", 4'b1111, 1'b1, 4'b0000, 1'b0);
    step("rot_g3",   4'b1111, 1'b0, 4'b1000, 1'b0);
    chk("enc3", 8'(enc(grant)), 8'd3);
    step("rot_rel3", 4'b1111, 1'b1, 4'b0000, 1'b0);
    step("rot_g0",   4'b1111, 1'b0, 4'b0001, 1'b0);

    // Holder drops req: next cycle idle; done while idle is ignored.
    step("drop_rel", 4'b0000, 1'b0, 4'b0000, 1'b0);
    step("idle_done", 4'b0000, 1'b1, 4'b0000, 1'b0);

    // Steer ptr to 2, then skip and wrap.
    step("to_ptr2",  4'b0010, 1'b0, 4'b0010, 1'b0);
    step("to_ptr2h", 4'b0010, 1'b0, 4'b0010, 1'b0);
    chk("ptr2", 8'(dut.ptr), 8'd2);
    step("to_ptr2r", 4'b0000, 1'b0, 4'b0000, 1'b0);
    step("wrap",     4'b0011, 1'b0, 4'b0001, 1'b0);
    chk("wrap_ptr", 8'(dut.ptr), 8'd1);
    step("wrap_rel", 4'b0011, 1'b1, 4'b0000, 1'b0);

    // Master 2 never releases: 15 grant cycles, then revocation; others toggling has no effect.
    step("to_g", 4'b0100, 1'b0, 4'b0100, 1'b0);
    for (int i = 1; i < 15; i++)
      step("to_hold", (i % 2 == 1) ? 4'b1100 : 4'b0111, 1'b0, 4'b0100, 1'b0);
    step("to_expire", 4'b1100, 1'b0, 4'b0000, 1'b1);
    step("to_next",   4'b1000, 1'b0, 4'b1000, 1'b0);

    // done coinciding with the expiry cycle is a normal release.
    for (int i = 1; i < 15; i++)
      step("col_hold", 4'b1000, 1'b0, 4'b1000, 1'b0);
    step("col_rel",  4'b1000, 1'b1, 4'b0000, 1'b0);
    step("col_idle", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Asynchronous reset between edges while master 3 holds.
    step("ar_g", 4'b1000, 1'b0, 4'b1000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", 8'(grant), 8'h00);
    chk("ar_valid", 8'(grant_valid), 8'h00);
    chk("ar_ptr", 8'(dut.ptr), 8'd0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst", 4'b0010, 1'b0, 4'b0010, 1'b0);
    chk("sb_empty", 8'(sb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
